// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet/ARP constants, receive FSM encoding and helpers.
// Ports: none (package).
package eth_pkg;

   localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
   localparam logic [15:0] ETH_TYPE_IP    = 16'h0800;
   localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
   localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
   localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
   localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
   localparam logic [7:0]  ARP_PLEN_IP    = 8'd4;
   localparam logic [3:0]  ARP_LAST_WORD  = 4'd10;
   localparam logic [47:0] ETH_BCAST      = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DRAIN,
      ST_DONE
   } arp_rx_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/arp_receiver.sv
// arp_receiver: parses a 32-bit ARP frame beat stream, validates the header, strobes decoded fields.
// Ports: clk, rst_n (async active-low); data_in/be_in/data_in_rdy/sop/eop in, data_in_rd out;
//        local_haddr/local_paddr own addresses; arp_valid/reply_req strobes; oper, mac_src_addr,
//        sender_/target_ haddr/paddr decoded fields; drop_cnt saturating reject counter.
// Build option: define ARP_RX_MAC_FILTER_EN to reject frames whose dst is neither broadcast nor local_haddr.
module arp_receiver
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_in,
   input  logic [1:0]  be_in,
   input  logic        data_in_rdy,
   output logic        data_in_rd,
   input  logic        sop,
   input  logic        eop,
   input  logic [47:0] local_haddr,
   input  logic [31:0] local_paddr,
   output logic        arp_valid,
   output logic        reply_req,
   output logic [15:0] oper,
   output logic [47:0] mac_src_addr,
   output logic [47:0] sender_haddr,
   output logic [47:0] target_haddr,
   output logic [31:0] sender_paddr,
   output logic [31:0] target_paddr,
   output logic [15:0] drop_cnt
);

   arp_rx_state_t state, state_nxt;
   logic [3:0]  w;
   logic        bad;
   logic        xfer, start, abort, done_ok;
   logic [47:0] src_sh, sha_sh, tha_sh;
   logic [31:0] spa_sh, tpa_sh;
   logic [15:0] oper_sh;
   logic [47:0] src_q, sha_q, tha_q;
   logic [31:0] spa_q, tpa_q;
   logic [15:0] oper_q;
   logic        unused_ok;

`ifdef ARP_RX_MAC_FILTER_EN
   logic [31:0] dst_hi;
   assign unused_ok = ^be_in;
`else
   assign unused_ok = ^{be_in, local_haddr};
`endif

   assign data_in_rd = (state != ST_DONE);
   assign xfer       = data_in_rdy & data_in_rd;
   // any accepted sop beat begins a new frame at w0, aborting one in flight
   assign start      = xfer & sop;
   assign abort      = start & ((state == ST_HDR) | (state == ST_DRAIN));
   assign done_ok    = (state == ST_DONE) & ~bad;

   // during DONE the freshly decoded fields are shown directly so they line up with arp_valid
   assign arp_valid    = done_ok;
   assign reply_req    = done_ok & (oper_sh == ARP_OP_REQUEST) & (tpa_sh == local_paddr);
   assign oper         = done_ok ? oper_sh : oper_q;
   assign mac_src_addr = done_ok ? src_sh  : src_q;
   assign sender_haddr = done_ok ? sha_sh  : sha_q;
   assign target_haddr = done_ok ? tha_sh  : tha_q;
   assign sender_paddr = done_ok ? spa_sh  : spa_q;
   assign target_paddr = done_ok ? tpa_sh  : tpa_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (start) state_nxt = eop ? ST_DONE : ST_HDR;
         ST_HDR, ST_DRAIN:
            if (start)
               state_nxt = eop ? ST_DONE : ST_HDR;
            else if (xfer && (eop || (state == ST_HDR && w == ARP_LAST_WORD)))
               state_nxt = eop ? ST_DONE : ST_DRAIN;
         ST_DONE:
            state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w        <= '0;
         bad      <= 1'b0;
         src_sh   <= '0;
         sha_sh   <= '0;
         tha_sh   <= '0;
         spa_sh   <= '0;
         tpa_sh   <= '0;
         oper_sh  <= '0;
         src_q    <= '0;
         sha_q    <= '0;
         tha_q    <= '0;
         spa_q    <= '0;
         tpa_q    <= '0;
         oper_q   <= '0;
         drop_cnt <= '0;
`ifdef ARP_RX_MAC_FILTER_EN
         dst_hi   <= '0;
`endif
      end else begin
         if (start) begin
            w   <= 4'd1;
            bad <= eop;
`ifdef ARP_RX_MAC_FILTER_EN
            dst_hi <= data_in;
`endif
         end else if (xfer && state == ST_HDR) begin
            w <= w + 4'd1;
            case (w)
               4'd1: begin
                  src_sh[47:32] <= data_in[15:0];
`ifdef ARP_RX_MAC_FILTER_EN
                  if ({dst_hi, data_in[31:16]} != ETH_BCAST && {dst_hi, data_in[31:16]} != local_haddr)
                     bad <= 1'b1;
`endif
               end
               4'd2: src_sh[31:0] <= data_in;
               4'd3: if (data_in[31:16] != ETH_TYPE_ARP || data_in[15:0] != ARP_HTYPE_ETH) bad <= 1'b1;
               4'd4: if (data_in[31:16] != ETH_TYPE_IP || data_in[15:8] != ARP_HLEN_ETH ||
                         data_in[7:0] != ARP_PLEN_IP) bad <= 1'b1;
               4'd5: begin
                  oper_sh        <= data_in[31:16];
                  sha_sh[47:32]  <= data_in[15:0];
                  if (data_in[31:16] != ARP_OP_REQUEST && data_in[31:16] != ARP_OP_REPLY) bad <= 1'b1;
               end
               4'd6: sha_sh[31:0] <= data_in;
               4'd7: spa_sh <= data_in;
               4'd8: tha_sh[47:16] <= data_in;
               4'd9: begin
                  tha_sh[15:0]  <= data_in[31:16];
                  tpa_sh[31:16] <= data_in[15:0];
               end
               4'd10: tpa_sh[15:0] <= data_in[31:16];
               default: ;
            endcase
            if (eop && w < ARP_LAST_WORD) bad <= 1'b1;
         end
         if (abort || (state == ST_DONE && bad)) drop_cnt <= sat_inc16(drop_cnt);
         if (done_ok) begin
            src_q  <= src_sh;
            sha_q  <= sha_sh;
            tha_q  <= tha_sh;
            spa_q  <= spa_sh;
            tpa_q  <= tpa_sh;
            oper_q <= oper_sh;
         end
      end
   end

endmodule

// File: tb/tb_arp_receiver.sv
// tb_arp_receiver: scoreboard-based self-checking bench for arp_receiver.
module tb_arp_receiver;

   localparam logic [47:0] LHA   = 48'h02AA_BBCC_DDEE;
   localparam logic [31:0] LPA   = 32'hC0A8_000A;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_in = '0;
   logic [1:0]  be_in = '0;
   logic        data_in_rdy = 1'b0;
   logic        data_in_rd;
   logic        sop = 1'b0;
   logic        eop = 1'b0;
   logic [47:0] local_haddr = LHA;
   logic [31:0] local_paddr = LPA;
   logic        arp_valid, reply_req;
   logic [15:0] oper, drop_cnt;
   logic [47:0] mac_src_addr, sender_haddr, target_haddr;
   logic [31:0] sender_paddr, target_paddr;

   arp_receiver dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .be_in(be_in),
      .data_in_rdy(data_in_rdy), .data_in_rd(data_in_rd), .sop(sop), .eop(eop),
      .local_haddr(local_haddr), .local_paddr(local_paddr),
      .arp_valid(arp_valid), .reply_req(reply_req), .oper(oper),
      .mac_src_addr(mac_src_addr), .sender_haddr(sender_haddr), .target_haddr(target_haddr),
      .sender_paddr(sender_paddr), .target_paddr(target_paddr), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [47:0] dst, src;
      logic [15:0] etype, htype, ptype;
      logic [7:0]  hlen, plen;
      logic [15:0] op;
      logic [47:0] sha;
      logic [31:0] spa;
      logic [47:0] tha;
      logic [31:0] tpa;
   } frame_t;

   typedef struct packed {
      logic [15:0] op;
      logic [47:0] src, sha, tha;
      logic [31:0] spa, tpa;
      logic        reply;
   } exp_t;

   exp_t        sb[$];
   exp_t        e, last;
   int          checks = 0;
   int          passed = 0;
   int          valid_seen = 0;
   logic [15:0] exp_drop = '0;
   logic [31:0] words[0:31];

   always @(negedge clk) if (arp_valid) valid_seen <= valid_seen + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   function automatic logic [15:0] sat(input int v);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   function automatic frame_t mk(input logic [15:0] op, input logic [47:0] dst, input logic [31:0] tpa);
      frame_t f;
      f.dst = dst; f.src = 48'h0011_2233_4455; f.etype = 16'h0806; f.htype = 16'h0001;
      f.ptype = 16'h0800; f.hlen = 8'd6; f.plen = 8'd4; f.op = op;
      f.sha = 48'h0011_2233_4455; f.spa = 32'hC0A8_0002;
      f.tha = (op == 16'd1) ? 48'h0 : LHA; f.tpa = tpa;
      return f;
   endfunction

   function automatic exp_t ex(input frame_t f);
      exp_t x;
      x.op = f.op; x.src = f.src; x.sha = f.sha; x.tha = f.tha; x.spa = f.spa; x.tpa = f.tpa;
      x.reply = (f.op == 16'd1) && (f.tpa == LPA);
      return x;
   endfunction

   function automatic exp_t obs();
      return {oper, mac_src_addr, sender_haddr, target_haddr, sender_paddr, target_paddr, reply_req};
   endfunction

   function automatic exp_t held(input exp_t x);
      exp_t h = x;
      h.reply = 1'b0;
      return h;
   endfunction

   task automatic build(input frame_t f, input int b);
      words[b+0]  = f.dst[47:16];
      words[b+1]  = {f.dst[15:0], f.src[47:32]};
      words[b+2]  = f.src[31:0];
      words[b+3]  = {f.etype, f.htype};
      words[b+4]  = {f.ptype, f.hlen, f.plen};
      words[b+5]  = {f.op, f.sha[47:32]};
      words[b+6]  = f.sha[31:0];
      words[b+7]  = f.spa;
      words[b+8]  = f.tha[47:16];
      words[b+9]  = {f.tha[15:0], f.tpa[31:16]};
      words[b+10] = {f.tpa[15:0], 16'h0000};
   endtask

   // drives n beats from words[]; ends at the negedge following the last transfer
   task automatic send(input int n, input bit gaps, input logic [31:0] sopm, input logic [31:0] eopm);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            @(negedge clk);
            data_in_rdy = 1'b0; sop = 1'b0; eop = 1'b0; data_in = $urandom;
         end
         @(negedge clk);
         data_in = words[i]; sop = sopm[i]; eop = eopm[i];
         be_in = eopm[i] ? 2'b10 : 2'b00; data_in_rdy = 1'b1;
         for (int t = 0; t < 4 && !data_in_rd; t++) @(negedge clk);
         if (!data_in_rd) begin
            checks++;
            $display("FAIL beat_accept %0d: data_in_rd=%b required 1", i, data_in_rd);
         end
         @(posedge clk);
      end
      @(negedge clk);
      data_in_rdy = 1'b0; sop = 1'b0; eop = 1'b0;
   endtask

   task automatic test_reset();
      frame_t f;
      repeat (3) @(negedge clk);
      checks++;
      if ({arp_valid, reply_req, data_in_rd, drop_cnt} !== {1'b0, 1'b0, 1'b1, 16'h0})
         $display("FAIL reset_ctrl: got v=%b r=%b rd=%b drop=%h required 0 0 1 0000",
                  arp_valid, reply_req, data_in_rd, drop_cnt);
      else passed++;
      checks++;
      if (obs() !== '0) $display("FAIL reset_fields: got %h required 0", obs());
      else passed++;
      rst_n = 1'b1;
      f = mk(16'd1, BCAST, LPA);
      build(f, 0);
      send(4, 0, 32'h1, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({data_in_rd, drop_cnt} !== {1'b1, 16'h0})
         $display("FAIL reset_midframe: got rd=%b drop=%h required 1 0000", data_in_rd, drop_cnt);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_request();
      frame_t f = mk(16'd1, BCAST, LPA);
      build(f, 0);
      sb.push_back(ex(f));
      send(11, 0, 32'h1, 32'h1 << 10);
      e = sb.pop_front();
      checks++;
      if ({arp_valid, obs()} !== {1'b1, e})
         $display("FAIL request_decode: got v=%b %h required v=1 %h", arp_valid, obs(), e);
      else passed++;
      last = held(e);
      @(negedge clk);
      checks++;
      if ({arp_valid, obs(), drop_cnt} !== {1'b0, last, exp_drop})
         $display("FAIL request_hold: got v=%b %h drop=%h required v=0 %h drop=%h",
                  arp_valid, obs(), drop_cnt, last, exp_drop);
      else passed++;
   endtask

   task automatic test_reply_throttled();
      frame_t f = mk(16'd2, LHA, LPA);
      f.src = 48'h0A0B_0C0D_0E0F; f.sha = 48'h0A0B_0C0D_0E0F; f.spa = 32'hC0A8_0063;
      build(f, 0);
      for (int i = 11; i < 15; i++) words[i] = $urandom;
      sb.push_back(ex(f));
      send(15, 1, 32'h1, 32'h1 << 14);
      e = sb.pop_front();
      checks++;
      if ({arp_valid, obs()} !== {1'b1, e})
         $display("FAIL reply_decode: got v=%b %h required v=1 %h", arp_valid, obs(), e);
      else passed++;
      last = held(e);
   endtask

   task automatic test_bad_type();
      frame_t f = mk(16'd1, BCAST, LPA);
      f.etype = 16'h0800; f.spa = 32'h0A000001;
      build(f, 0);
      send(11, 0, 32'h1, 32'h1 << 10);
      exp_drop = sat(exp_drop + 1);
      checks++;
      if ({arp_valid, obs()} !== {1'b0, last})
         $display("FAIL bad_type_done: got v=%b %h required v=0 %h", arp_valid, obs(), last);
      else passed++;
      @(negedge clk);
      checks++;
      if (drop_cnt !== exp_drop) $display("FAIL bad_type_drop: got %h required %h", drop_cnt, exp_drop);
      else passed++;
   endtask

   task automatic test_short();
      frame_t f = mk(16'd1, BCAST, LPA);
      build(f, 0);
      send(7, 0, 32'h1, 32'h1 << 6);
      exp_drop = sat(exp_drop + 1);
      checks++;
      if (arp_valid !== 1'b0) $display("FAIL short_done: got v=%b required 0", arp_valid);
      else passed++;
      @(negedge clk);
      checks++;
      if (drop_cnt !== exp_drop) $display("FAIL short_drop: got %h required %h", drop_cnt, exp_drop);
      else passed++;
      f.spa = 32'hC0A8_0007; f.tpa = 32'hC0A8_0099;
      build(f, 0);
      sb.push_back(ex(f));
      send(11, 0, 32'h1, 32'h1 << 10);
      e = sb.pop_front();
      checks++;
      if ({arp_valid, obs(), drop_cnt} !== {1'b1, e, exp_drop})
         $display("FAIL short_next: got v=%b %h drop=%h required v=1 %h drop=%h",
                  arp_valid, obs(), drop_cnt, e, exp_drop);
      else passed++;
      last = held(e);
   endtask

   task automatic test_bad_fields();
      for (int k = 0; k < 3; k++) begin
         frame_t f = mk(16'd1, BCAST, LPA);
         if (k == 0) f.op = 16'd3;
         if (k == 1) f.hlen = 8'd7;
         if (k == 2) f.ptype = 16'h86DD;
         build(f, 0);
         send(11, 0, 32'h1, 32'h1 << 10);
         exp_drop = sat(exp_drop + 1);
         checks++;
         if (arp_valid !== 1'b0) $display("FAIL bad_field%0d_done: got v=%b required 0", k, arp_valid);
         else passed++;
         @(negedge clk);
         checks++;
         if (drop_cnt !== exp_drop) $display("FAIL bad_field%0d_drop: got %h required %h", k, drop_cnt, exp_drop);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      frame_t a = mk(16'd1, BCAST, LPA);
      frame_t b = mk(16'd2, LHA, 32'hC0A8_0001);
      int v0;
      b.src = 48'h0200_0000_0042; b.sha = 48'h0200_0000_0042; b.spa = 32'hC0A8_0042;
      build(a, 0);
      build(b, 11);
      sb.push_back(ex(b));
      v0 = valid_seen;
      send(22, 0, 32'h1 | (32'h1 << 11), (32'h1 << 10) | (32'h1 << 21));
      e = sb.pop_front();
      checks++;
      if ({arp_valid, obs()} !== {1'b1, e})
         $display("FAIL b2b_decode: got v=%b %h required v=1 %h", arp_valid, obs(), e);
      else passed++;
      last = held(e);
      @(negedge clk);
      checks++;
      if ({valid_seen - v0, drop_cnt} !== {32'd2, exp_drop})
         $display("FAIL b2b_count: got pulses=%0d drop=%h required 2 %h", valid_seen - v0, drop_cnt, exp_drop);
      else passed++;
   endtask

   task automatic test_abort(input string tag);
      frame_t f = mk(16'd1, BCAST, LPA);
      f.spa = 32'hC0A8_0055;
      build(f, 0);
      send(6, 0, 32'h1, 32'h0);
      f.spa = 32'hC0A8_0066; f.src = 48'h0600_0000_0066;
      build(f, 0);
      sb.push_back(ex(f));
      send(11, 0, 32'h1, 32'h1 << 10);
      exp_drop = sat(exp_drop + 1);
      e = sb.pop_front();
      checks++;
      if ({arp_valid, obs(), drop_cnt} !== {1'b1, e, exp_drop})
         $display("FAIL abort_%s: got v=%b %h drop=%h required v=1 %h drop=%h",
                  tag, arp_valid, obs(), drop_cnt, e, exp_drop);
      else passed++;
      last = held(e);
   endtask

   task automatic test_saturation();
      frame_t f;
      for (int i = 0; i < 65540; i++) begin
         @(negedge clk);
         data_in = $urandom; sop = 1'b1; eop = 1'b0; data_in_rdy = 1'b1;
      end
      @(negedge clk);
      data_in_rdy = 1'b0; sop = 1'b0;
      exp_drop = sat(exp_drop + 65539);
      checks++;
      if (drop_cnt !== exp_drop) $display("FAIL sat_stream: got %h required %h", drop_cnt, exp_drop);
      else passed++;
      test_abort("sat");
      f = mk(16'd1, BCAST, LPA);
      f.etype = 16'h0801;
      build(f, 0);
      send(11, 0, 32'h1, 32'h1 << 10);
      @(negedge clk);
      checks++;
      if (drop_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h required ffff", drop_cnt);
      else passed++;
   endtask

   task automatic test_dst_filter();
      frame_t f = mk(16'd1, 48'h0200_0000_0001, LPA);
      f.spa = 32'hC0A8_0011;
      build(f, 0);
`ifdef ARP_RX_MAC_FILTER_EN
      send(11, 0, 32'h1, 32'h1 << 10);
      exp_drop = sat(exp_drop + 1);
      @(negedge clk);
      checks++;
      if ({arp_valid, drop_cnt} !== {1'b0, exp_drop})
         $display("FAIL filter_reject: got v=%b drop=%h required 0 %h", arp_valid, drop_cnt, exp_drop);
      else passed++;
      f.dst = BCAST;
      build(f, 0);
`endif
      sb.push_back(ex(f));
      send(11, 0, 32'h1, 32'h1 << 10);
      e = sb.pop_front();
      checks++;
      if ({arp_valid, obs()} !== {1'b1, e})
         $display("FAIL filter_accept: got v=%b %h required v=1 %h", arp_valid, obs(), e);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_request();
      test_reply_throttled();
      test_bad_type();
      test_short();
      test_bad_fields();
      test_back_to_back();
      test_abort("plain");
      test_dst_filter();
      test_saturation();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
